// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, aux unit results queue in a small FIFO.
// Optional statistics counters are enabled by defining RF_WB_ARB_STATS_EN.
module rf_wb_arbiter #(
    parameter int AUX_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_wd,
    input  logic        aux_valid,
    output logic        aux_ready,
    input  logic [4:0]  aux_rd,
    input  logic [31:0] aux_wd,
    output logic        pipe_stall,
    output logic        rf_we,
    output logic [4:0]  rf_a,
    output logic [31:0] rf_wd,
    output logic [31:0] aux_busy_mask
`ifdef RF_WB_ARB_STATS_EN
    ,
    output logic [31:0] stat_conflicts,
    output logic [31:0] stat_forced
`endif
);
    localparam int PTR_W = $clog2(AUX_DEPTH);

    typedef enum logic [1:0] {IDLE, DRAIN, FORCE} state_t;

    state_t             state_reg;
    logic [3:0]         starve_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic [PTR_W:0]     count_next;
    logic [AUX_DEPTH-1:0] valid_reg;
    logic [4:0]         mem_rd [AUX_DEPTH];
    logic [31:0]        mem_wd [AUX_DEPTH];
    logic [31:0]        entry_mask [AUX_DEPTH];

    logic full;
    logic pipe_busy;
    logic push;
    logic pop;
    logic enter_force;

    assign full        = (count_reg == (PTR_W+1)'(AUX_DEPTH));
    assign aux_ready   = !full;
    assign pipe_busy   = pipe_we && (pipe_rd != 5'd0);
    // Writes to x0 complete the handshake but are never stored.
    assign push        = aux_valid && !full && (aux_rd != 5'd0);
    assign pop         = ((state_reg == DRAIN) && !pipe_busy) || (state_reg == FORCE);
    assign enter_force = (state_reg == DRAIN) && pipe_busy &&
                         ((starve_reg + 4'd1) == 4'(STARVE_MAX));
    assign count_next  = count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    assign pipe_stall  = (state_reg == FORCE);

    always_comb begin
        rf_we = 1'b0;
        rf_a  = 5'd0;
        rf_wd = 32'd0;
        if (pop) begin
            rf_we = 1'b1;
            rf_a  = mem_rd[rd_ptr_reg];
            rf_wd = mem_wd[rd_ptr_reg];
        end else if (pipe_busy) begin
            rf_we = 1'b1;
            rf_a  = pipe_rd;
            rf_wd = pipe_wd;
        end
    end

    // Storage carries no reset; validity is tracked separately in valid_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr_reg] <= aux_rd;
            mem_wd[wr_ptr_reg] <= aux_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            starve_reg <= 4'd0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg            <= wr_ptr_reg + 1'b1;
                valid_reg[wr_ptr_reg] <= 1'b1;
            end
            if (pop) begin
                rd_ptr_reg            <= rd_ptr_reg + 1'b1;
                valid_reg[rd_ptr_reg] <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    starve_reg <= 4'd0;
                    if (count_next != '0) state_reg <= DRAIN;
                end
                DRAIN: begin
                    if (count_next == '0) begin
                        state_reg  <= IDLE;
                        starve_reg <= 4'd0;
                    end else if (enter_force) begin
                        state_reg  <= FORCE;
                        starve_reg <= 4'd0;
                    end else if (pipe_busy) begin
                        starve_reg <= starve_reg + 4'd1;
                    end else begin
                        starve_reg <= 4'd0;
                    end
                end
                default: begin
                    starve_reg <= 4'd0;
                    state_reg  <= (count_next != '0) ? DRAIN : IDLE;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < AUX_DEPTH; gi++) begin : g_mask
        assign entry_mask[gi] = valid_reg[gi] ? (32'd1 << mem_rd[gi]) : 32'd0;
    end

    always_comb begin
        aux_busy_mask = 32'd0;
        for (int i = 0; i < AUX_DEPTH; i++) begin
            aux_busy_mask = aux_busy_mask | entry_mask[i];
        end
    end

`ifdef RF_WB_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_conflicts <= 32'd0;
            stat_forced    <= 32'd0;
        end else begin
            if (pipe_busy && (count_reg != '0) && (stat_conflicts != 32'hFFFF_FFFF))
                stat_conflicts <= stat_conflicts + 32'd1;
            if (enter_force && (stat_forced != 32'hFFFF_FFFF))
                stat_forced <= stat_forced + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (default build, statistics disabled).
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wd;
    logic        aux_valid;
    logic        aux_ready;
    logic [4:0]  aux_rd;
    logic [31:0] aux_wd;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_a;
    logic [31:0] rf_wd;
    logic [31:0] aux_busy_mask;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pipe_we       (pipe_we),
        .pipe_rd       (pipe_rd),
        .pipe_wd       (pipe_wd),
        .aux_valid     (aux_valid),
        .aux_ready     (aux_ready),
        .aux_rd        (aux_rd),
        .aux_wd        (aux_wd),
        .pipe_stall    (pipe_stall),
        .rf_we         (rf_we),
        .rf_a          (rf_a),
        .rf_wd         (rf_wd),
        .aux_busy_mask (aux_busy_mask)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; pipe_we = 1'b0; pipe_rd = 5'd0; pipe_wd = 32'd0;
        aux_valid = 1'b0; aux_rd = 5'd0; aux_wd = 32'd0;
        #2;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0b want 0", rf_we); end
        checks++; if (rf_a !== 5'd0) begin errors++; $display("FAIL reset_rf_a: got %0d want 0", rf_a); end
        checks++; if (rf_wd !== 32'd0) begin errors++; $display("FAIL reset_rf_wd: got %h want 0", rf_wd); end
        checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", pipe_stall); end
        checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", aux_ready); end
        checks++; if (aux_busy_mask !== 32'd0) begin errors++; $display("FAIL reset_mask: got %h want 0", aux_busy_mask); end
        @(negedge clk); rst_n = 1'b1;
        tick;
        $display("reset: outputs checked");
    endtask

    task automatic test_pipe_only;
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'hA5A5_0001;
        #1;
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL pipe_we: got %0b want 1", rf_we); end
        checks++; if (rf_a !== 5'd5) begin errors++; $display("FAIL pipe_a: got %0d want 5", rf_a); end
        checks++; if (rf_wd !== 32'hA5A5_0001) begin errors++; $display("FAIL pipe_wd: got %h want a5a50001", rf_wd); end
        tick;
        pipe_we = 1'b0;
        #1;
        checks++; if (aux_busy_mask !== 32'd0 || aux_ready !== 1'b1 || rf_we !== 1'b0) begin
            errors++; $display("FAIL pipe_idle_after: mask=%h ready=%0b we=%0b want 0/1/0", aux_busy_mask, aux_ready, rf_we);
        end
        tick;
        $display("pipe_only: rd=5 wd=a5a50001 written same cycle");
    endtask

    task automatic test_x0_filter;
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wd = 32'hDEAD_BEEF;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_pipe: rf_we got %0b want 0", rf_we); end
        pipe_we = 1'b0;
        aux_valid = 1'b1; aux_rd = 5'd0; aux_wd = 32'h5555_5555;
        tick;
        aux_valid = 1'b0;
        #1;
        checks++; if (aux_busy_mask !== 32'd0) begin errors++; $display("FAIL x0_aux_mask: got %h want 0", aux_busy_mask); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_aux_write: rf_we got %0b want 0", rf_we); end
        tick;
        checks++; if (rf_we !== 1'b0 || aux_ready !== 1'b1) begin
            errors++; $display("FAIL x0_aux_late: we=%0b ready=%0b want 0/1", rf_we, aux_ready);
        end
        $display("x0_filter: pipe and aux writes to x0 dropped");
    endtask

    task automatic test_aux_idle;
        aux_valid = 1'b1; aux_rd = 5'd7; aux_wd = 32'h0000_1234;
        tick;
        aux_valid = 1'b0;
        #1;
        checks++; if (aux_busy_mask !== 32'h0000_0080) begin errors++; $display("FAIL aux_mask7: got %h want 00000080", aux_busy_mask); end
        checks++; if (rf_we !== 1'b1 || rf_a !== 5'd7 || rf_wd !== 32'h0000_1234) begin
            errors++; $display("FAIL aux_write7: we=%0b a=%0d wd=%h want 1/7/00001234", rf_we, rf_a, rf_wd);
        end
        tick;
        checks++; if (aux_busy_mask !== 32'd0 || rf_we !== 1'b0) begin
            errors++; $display("FAIL aux_after7: mask=%h we=%0b want 0/0", aux_busy_mask, rf_we);
        end
        $display("aux_idle: rd=7 wd=1234 written one cycle after accept");
    endtask

    task automatic test_starvation;
        aux_valid = 1'b1; aux_rd = 5'd9; aux_wd = 32'h0000_0099;
        tick;
        aux_valid = 1'b0;
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h0000_0033;
        #1;
        checks++; if (aux_busy_mask !== 32'h0000_0200) begin errors++; $display("FAIL starve_mask: got %h want 00000200", aux_busy_mask); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rf_a !== 5'd3 || pipe_stall !== 1'b0) begin
                errors++; $display("FAIL starve_pipe%0d: a=%0d stall=%0b want 3/0", i, rf_a, pipe_stall);
            end
            tick;
        end
        checks++; if (pipe_stall !== 1'b1 || rf_a !== 5'd9 || rf_wd !== 32'h0000_0099) begin
            errors++; $display("FAIL starve_force: stall=%0b a=%0d wd=%h want 1/9/00000099", pipe_stall, rf_a, rf_wd);
        end
        tick;
        checks++; if (pipe_stall !== 1'b0 || rf_a !== 5'd3 || aux_busy_mask !== 32'd0) begin
            errors++; $display("FAIL starve_after: stall=%0b a=%0d mask=%h want 0/3/0", pipe_stall, rf_a, aux_busy_mask);
        end
        pipe_we = 1'b0;
        tick;
        $display("starvation: forced grant of rd=9 after 4 denied cycles");
    endtask

    task automatic test_full;
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h0000_0033;
        aux_valid = 1'b1; aux_rd = 5'd10; aux_wd = 32'h0000_000A;
        tick;
        aux_rd = 5'd11; aux_wd = 32'h0000_000B;
        #1;
        checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL full_ready1: got %0b want 1", aux_ready); end
        tick;
        aux_rd = 5'd12; aux_wd = 32'h0000_000C;
        #1;
        checks++; if (aux_ready !== 1'b0 || aux_busy_mask !== 32'h0000_0C00 || rf_a !== 5'd3) begin
            errors++; $display("FAIL full_state: ready=%0b mask=%h a=%0d want 0/00000c00/3", aux_ready, aux_busy_mask, rf_a);
        end
        tick;
        checks++; if (aux_ready !== 1'b0 || aux_busy_mask !== 32'h0000_0C00) begin
            errors++; $display("FAIL full_hold: ready=%0b mask=%h want 0/00000c00", aux_ready, aux_busy_mask);
        end
        pipe_we = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_a !== 5'd10 || aux_ready !== 1'b0) begin
            errors++; $display("FAIL full_pop10: we=%0b a=%0d ready=%0b want 1/10/0", rf_we, rf_a, aux_ready);
        end
        tick;
        checks++; if (rf_a !== 5'd11 || aux_ready !== 1'b1 || aux_busy_mask !== 32'h0000_0800) begin
            errors++; $display("FAIL full_pop11: a=%0d ready=%0b mask=%h want 11/1/00000800", rf_a, aux_ready, aux_busy_mask);
        end
        tick;
        aux_valid = 1'b0;
        #1;
        checks++; if (rf_a !== 5'd12 || rf_wd !== 32'h0000_000C || aux_busy_mask !== 32'h0000_1000) begin
            errors++; $display("FAIL full_pop12: a=%0d wd=%h mask=%h want 12/0000000c/00001000", rf_a, rf_wd, aux_busy_mask);
        end
        tick;
        checks++; if (aux_busy_mask !== 32'd0 || rf_we !== 1'b0) begin
            errors++; $display("FAIL full_empty: mask=%h we=%0b want 0/0", aux_busy_mask, rf_we);
        end
        $display("full: third push held off until a pop, order 10,11,12");
    endtask

    task automatic test_reset_mid;
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wd = 32'h0000_0033;
        aux_valid = 1'b1; aux_rd = 5'd20; aux_wd = 32'h0000_0014;
        tick;
        aux_rd = 5'd21; aux_wd = 32'h0000_0015;
        tick;
        aux_valid = 1'b0;
        pipe_we = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_a !== 5'd20) begin
            errors++; $display("FAIL rstmid_pre: we=%0b a=%0d want 1/20", rf_we, rf_a);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0 || aux_busy_mask !== 32'd0 || aux_ready !== 1'b1 || pipe_stall !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: we=%0b mask=%h ready=%0b stall=%0b want 0/0/1/0", rf_we, aux_busy_mask, aux_ready, pipe_stall);
        end
        tick;
        tick;
        @(negedge clk); rst_n = 1'b1;
        tick;
        checks++; if (rf_we !== 1'b0 || aux_busy_mask !== 32'd0) begin
            errors++; $display("FAIL rstmid_release: we=%0b mask=%h want 0/0", rf_we, aux_busy_mask);
        end
        tick;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_stale: we=%0b want 0", rf_we); end
        $display("reset_mid: pending entries dropped");
    endtask

    initial begin
        test_reset;
        test_pipe_only;
        test_x0_filter;
        test_aux_idle;
        test_starvation;
        test_full;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
